// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and helpers shared by the ALU result checker.
package alu_pkg;
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_XOR = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_DIV = 3'b101;

   function automatic logic parity_checked(input logic [2:0] opcode, input logic bypass);
      return !bypass && opcode >= OP_ADD && opcode <= OP_DIV;
   endfunction

   function automatic int res_w(input int width);
      return 2 * width + 1;
   endfunction
endpackage

// File: rtl/alu_result_checker_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO; head is shown combinationally, zero when empty.
module sync_fifo #(
   parameter int DW    = 11,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic          do_push, do_pop;

   always_comb begin
      full     = count_q == CW'(DEPTH);
      empty    = count_q == '0;
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      dout     = empty ? '0 : mem_q[rd_ptr_q];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: reads are masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/alu_result_checker.sv
// alu_result_checker: accepts ALU results, checks odd parity on arithmetic ops,
// buffers {par_err, invalid, result} and keeps saturating error counters.
module alu_result_checker
   import alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*WIDTH:0] in_result,
   input  logic             in_parity,
   input  logic             in_invalid,
   input  logic [2:0]       in_opcode,
   input  logic             in_bypass,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*WIDTH:0] out_result,
   output logic             out_par_err,
   output logic             out_invalid,
   input  logic             clear_counts,
   output logic [CNT_W-1:0] par_err_count,
   output logic [CNT_W-1:0] invalid_count
);
   localparam int RW = res_w(WIDTH);

   logic             par_err, push, full, empty;
   logic [RW+1:0]    fifo_out;
   logic [CNT_W-1:0] par_err_count_q, par_err_count_d, invalid_count_q, invalid_count_d;

   always_comb begin
      par_err         = parity_checked(in_opcode, in_bypass) && (in_parity != ~(^in_result));
      in_ready        = !full;
      push            = in_valid && in_ready;
      par_err_count_d = clear_counts ? '0
                      : (push && par_err && par_err_count_q != '1) ? par_err_count_q + 1'b1
                      : par_err_count_q;
      invalid_count_d = clear_counts ? '0
                      : (push && in_invalid && invalid_count_q != '1) ? invalid_count_q + 1'b1
                      : invalid_count_q;
      {out_par_err, out_invalid, out_result} = fifo_out;
      out_valid       = !empty;
      par_err_count   = par_err_count_q;
      invalid_count   = invalid_count_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_err_count_q <= '0;
         invalid_count_q <= '0;
      end else begin
         par_err_count_q <= par_err_count_d;
         invalid_count_q <= invalid_count_d;
      end
   end

   sync_fifo #(.DW(RW + 2), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (out_valid && out_ready),
      .din   ({par_err, in_invalid, in_result}),
      .dout  (fifo_out),
      .full  (full),
      .empty (empty)
   );
endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: directed scoreboard bench for alu_result_checker.
module tb_alu_result_checker;
   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0, in_ready;
   logic [2*WIDTH:0] in_result = '0;
   logic             in_parity = 1'b0, in_invalid = 1'b0, in_bypass = 1'b0;
   logic [2:0]       in_opcode = 3'b000;
   logic             out_valid, out_ready = 1'b0;
   logic [2*WIDTH:0] out_result;
   logic             out_par_err, out_invalid;
   logic             clear_counts = 1'b0;
   logic [CNT_W-1:0] par_err_count, invalid_count;

   int            passed = 0, total = 0;
   logic [10:0]   sb[$];
   logic [7:0]    exp_pe = 8'h00, exp_inv = 8'h00;

   alu_result_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_result(in_result), .in_parity(in_parity), .in_invalid(in_invalid),
      .in_opcode(in_opcode), .in_bypass(in_bypass), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_par_err(out_par_err),
      .out_invalid(out_invalid), .clear_counts(clear_counts),
      .par_err_count(par_err_count), .invalid_count(invalid_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One cycle, entered just after a falling edge: drive, check head, clock, update model, check counters.
   task automatic step(input logic v, input logic [8:0] res, input logic par, input logic inv,
                       input logic [2:0] op, input logic byp, input logic rdy, input logic clr);
      logic acc, pe;
      in_valid = v; in_result = res; in_parity = par; in_invalid = inv;
      in_opcode = op; in_bypass = byp; out_ready = rdy; clear_counts = clr;
      #1;
      chk("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) chk("head", 32'({out_par_err, out_invalid, out_result}), 32'(sb[0]));
      acc = v && sb.size() < DEPTH;
      pe  = !byp && op >= 3'd2 && op <= 3'd5 && ((^{res, par}) == 1'b0);
      @(posedge clk);
      if (rdy && sb.size() != 0) void'(sb.pop_front());
      if (acc) sb.push_back({pe, inv, res});
      if (clr) begin
         exp_pe = 8'h00; exp_inv = 8'h00;
      end else if (acc) begin
         if (pe && exp_pe != 8'hFF) exp_pe = exp_pe + 8'h01;
         if (inv && exp_inv != 8'hFF) exp_inv = exp_inv + 8'h01;
      end
      @(negedge clk);
      chk("par_err_count", 32'(par_err_count), 32'(exp_pe));
      chk("invalid_count", 32'(invalid_count), 32'(exp_inv));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_result", 32'({out_par_err, out_invalid, out_result}), 32'd0);
      chk("rst par_err_count", 32'(par_err_count), 32'd0);
      chk("rst invalid_count", 32'(invalid_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      // Parity cases: good ADD, bad MUL, unchecked AND, bypassed ADD.
      step(1, 9'h003, 1, 0, 3'b010, 0, 1, 0);
      step(1, 9'h003, 0, 0, 3'b011, 0, 1, 0);
      step(1, 9'h003, 0, 0, 3'b000, 0, 1, 0);
      step(1, 9'h003, 0, 0, 3'b010, 1, 1, 0);
      step(1, 9'h0F0, 1, 1, 3'b111, 0, 1, 0);
      step(0, 9'h000, 0, 0, 3'b000, 0, 1, 0);
      step(0, 9'h000, 0, 0, 3'b000, 0, 1, 0);
      // Fill to full with out_ready low, offer a fifth, then drain.
      for (int i = 0; i < 5; i++) step(1, 9'(8'h11 * (i + 1)), 1'(i), 0, 3'b100, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 9'h000, 0, 0, 3'b000, 0, 1, 0);
      // Saturate the invalid counter, then clear in the same cycle as a counting push.
      for (int i = 0; i < 300; i++) step(1, 9'(i), 0, 1, 3'b001, 0, 1, 0);
      chk("inv saturated", 32'(invalid_count), 32'hFF);
      step(1, 9'h1AA, 0, 1, 3'b001, 0, 1, 1);
      chk("inv cleared", 32'(invalid_count), 32'h00);
      step(0, 9'h000, 0, 0, 3'b000, 0, 1, 0);
      // Fill three entries, then reset asynchronously between edges.
      for (int i = 0; i < 3; i++) step(1, 9'(9'h101 + i), 1'(^(9'h101 + i)), 1, 3'b010, 0, 0, 0);
      chk("pre-reset par_err_count", 32'(par_err_count), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      sb.delete(); exp_pe = 8'h00; exp_inv = 8'h00;
      chk("async rst out_valid", 32'(out_valid), 32'd0);
      chk("async rst in_ready", 32'(in_ready), 32'd1);
      chk("async rst par_err_count", 32'(par_err_count), 32'd0);
      chk("async rst invalid_count", 32'(invalid_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 9'h000, 0, 0, 3'b000, 0, 1, 0);
      step(0, 9'h000, 0, 0, 3'b000, 0, 1, 0);
      // Streaming push and pop: occupancy one, pointers wrap several times.
      for (int i = 0; i < 20; i++) step(1, 9'(i * 23 + 5), 1'(i % 3 == 0), 1'(i % 2), 3'(i), 0, 1, 0);
      step(0, 9'h000, 0, 0, 3'b000, 0, 1, 0);
      step(0, 9'h000, 0, 0, 3'b000, 0, 1, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
